// File: rtl/mips16_prog_loader.sv
// Loads a framed byte stream (length, big-endian words, XOR checksum) into instruction
// memory and holds the CPU in reset until a complete, checksum-verified image is present.
module mips16_prog_loader #(
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte is consumed on a rising edge where in_valid && in_ready; upstream
  // must hold in_data stable while in_valid=1 and in_ready=0. in_ready never depends on in_valid.

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       len_hi;
  logic [15:0]      len;
  logic [7:0]       data_hi;
  logic [7:0]       csum;
  logic [CNT_W-1:0] cnt;

  logic        hs;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;
  logic        ready_nxt;
  logic        restart;

  assign hs        = in_valid && in_ready;
  assign len_full  = {len_hi, in_data};
  assign len_bad   = (len_full == 16'd0) || (len_full > 16'(MAX_WORDS));
  assign last_word = (16'(cnt) + 16'd1) == len;
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_HI;
      S_LEN_HI:  if (hs) state_nxt = S_LEN_LO;
      S_LEN_LO:  if (hs) state_nxt = len_bad ? S_ERROR : S_DATA_HI;
      S_DATA_HI: if (hs) state_nxt = S_DATA_LO;
      S_DATA_LO: if (hs) state_nxt = last_word ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (hs) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
      default:   state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO) ||
                (state_nxt == S_CHECK);
  end

  // Status outputs are registered from the next state so they all move together
  // on the edge that completes the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      len_hi     <= '0;
      len        <= '0;
      data_hi    <= '0;
      csum       <= '0;
      cnt        <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= ready_nxt;
      cpu_rst  <= (state_nxt != S_DONE);
      done     <= (state_nxt == S_DONE);
      error    <= (state_nxt == S_ERROR);
      imem_we  <= 1'b0;
      if (restart) begin
        csum <= '0;
        cnt  <= '0;
      end
      if (hs) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= in_data;
            csum   <= csum ^ in_data;
          end
          S_LEN_LO: begin
            len  <= len_full;
            csum <= csum ^ in_data;
          end
          S_DATA_HI: begin
            data_hi <= in_data;
            csum    <= csum ^ in_data;
          end
          S_DATA_LO: begin
            imem_we    <= 1'b1;
            imem_addr  <= ADDR_W'(cnt);
            imem_wdata <= {data_hi, in_data};
            cnt        <= cnt + 1'b1;
            csum       <= csum ^ in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips16_prog_loader.sv
// Bench for mips16_prog_loader: directed frame table, hand-written reload/reset sequences,
// and random frames checked against a whole-frame reference model.
module tb_mips16_prog_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_rst, done, error;
  logic [12:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [2:0]  dbg_state;

  mips16_prog_loader #(.ADDR_W(13), .MAX_WORDS(8192)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [28:0] exp_q[$];
  logic [7:0]  frame_q[$];
  bit          exp_done, exp_error, len_ok;
  int          exp_n, bytes_used;
  int          we_count = 0;
  logic        prev_we = 1'b0;
  logic [28:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Write scoreboard: every strobe must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_count++;
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) fail("write_expected");
      else begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", {3'd0, imem_addr, imem_wdata}, {3'd0, exp_w});
      end
    end
    prev_we = imem_we;
  end

  // Reference model: interprets the whole frame from the framing rules.
  task automatic model_frame();
    logic [7:0] x;
    int n;
    exp_done  = 0;
    exp_error = 0;
    n = {frame_q[0], frame_q[1]};
    if (n == 0 || n > 8192) begin
      len_ok = 0; exp_n = 0; exp_error = 1; bytes_used = 2;
      return;
    end
    len_ok = 1; exp_n = n; bytes_used = 3 + 2 * n;
    x = 8'h00;
    for (int i = 0; i < 2 + 2 * n; i++) x = x ^ frame_q[i];
    for (int w = 0; w < n; w++) exp_q.push_back({13'(w), frame_q[2 + 2 * w], frame_q[3 + 2 * w]});
    if (frame_q[2 + 2 * n] == x) exp_done = 1;
    else exp_error = 1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) begin
      fail("handshake_timeout");
      in_valid = 1'b0;
      ok = 0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1;
  endtask

  task automatic send_frame(input int gap_max, input bit start_mid);
    bit ok;
    int we0;
    we0 = we_count;
    pulse_start();
    for (int i = 0; i < bytes_used; i++) begin
      if (gap_max > 0) begin
        int g = $urandom_range(0, gap_max);
        repeat (g) begin
          start = start_mid && ($urandom_range(0, 3) == 0);
          @(negedge clk);
          start = 1'b0;
        end
      end
      send_byte(frame_q[i], ok);
      if (!ok) return;
      if (len_ok && i >= 3 && (i % 2) == 1 && i < 2 + 2 * exp_n)
        check("we_latency", {31'd0, imem_we}, 32'd1);
    end
    check("done_timing", {31'd0, done}, {31'd0, exp_done});
    check("error_timing", {31'd0, error}, {31'd0, exp_error});
    check("cpu_rst_state", {31'd0, cpu_rst}, {31'd0, !exp_done});
    check("in_ready_drop", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("writes_drained", exp_q.size(), 32'd0);
    check("write_count", we_count - we0, exp_n);
  endtask

  task automatic build_random(input int kind);
    int n;
    logic [7:0] x, d;
    frame_q = {};
    if (kind == 5) n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(8193, 65535);
    else n = $urandom_range(1, 8);
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    if (kind == 5) return;
    x = frame_q[0] ^ frame_q[1];
    for (int i = 0; i < 2 * n; i++) begin
      d = 8'($urandom_range(0, 255));
      frame_q.push_back(d);
      x = x ^ d;
    end
    frame_q.push_back(kind == 4 ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
  endtask

  typedef struct {
    int               nb;
    logic [0:8][7:0]  b;
    bit               e_done;
    bit               e_err;
    int               e_writes;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #1_000_000;
    fail("global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit ok;
    int we0;

    tbl[0] = '{7, {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00, 8'h00}, 1'b1, 1'b0, 2};
    tbl[1] = '{7, {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 8'h00, 8'h00}, 1'b0, 1'b1, 2};
    tbl[2] = '{2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0};
    tbl[3] = '{2, {8'h20, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {19'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
    rst = 1'b0;

    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    check("idle_not_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    for (int k = 0; k < 4; k++) begin
      frame_q = {};
      for (int j = 0; j < tbl[k].nb; j++) frame_q.push_back(tbl[k].b[j]);
      model_frame();
      we0 = we_count;
      send_frame(0, 0);
      check("tbl_done", {31'd0, done}, {31'd0, tbl[k].e_done});
      check("tbl_error", {31'd0, error}, {31'd0, tbl[k].e_err});
      check("tbl_cpu_rst", {31'd0, cpu_rst}, {31'd0, !tbl[k].e_done});
      check("tbl_writes", we_count - we0, tbl[k].e_writes);
    end

    // Backpressure gaps with stray start pulses mid-load.
    frame_q = {};
    for (int j = 0; j < tbl[0].nb; j++) frame_q.push_back(tbl[0].b[j]);
    model_frame();
    send_frame(4, 1);
    check("gap_done", {31'd0, done}, 32'd1);

    // Reload from DONE, then reset mid-load.
    pulse_start();
    check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("reload_done_clr", {31'd0, done}, 32'd0);
    check("reload_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({13'd0, 16'h1234});
    send_byte(8'h00, ok); send_byte(8'h02, ok);
    send_byte(8'h12, ok); send_byte(8'h34, ok); send_byte(8'hAB, ok);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_imem_we", {31'd0, imem_we}, 32'd0);
    check("midrst_addr", {19'd0, imem_addr}, 32'd0);
    check("midrst_wdata", {16'd0, imem_wdata}, 32'd0);
    check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midrst_flags", {30'd0, done, error}, 32'd0);
    check("midrst_writes", exp_q.size(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q = {};
    frame_q = {};
    for (int j = 0; j < tbl[0].nb; j++) frame_q.push_back(tbl[0].b[j]);
    model_frame();
    send_frame(0, 0);

    for (int r = 0; r < 24; r++) begin
      build_random($urandom_range(0, 5));
      model_frame();
      send_frame(3, 1);
    end

    // Largest image: last write lands at 8191.
    build_random(0);
    frame_q = {};
    begin
      logic [7:0] x, d;
      frame_q.push_back(8'h20); frame_q.push_back(8'h00);
      x = 8'h20;
      for (int i = 0; i < 16384; i++) begin
        d = 8'($urandom_range(0, 255));
        frame_q.push_back(d);
        x = x ^ d;
      end
      frame_q.push_back(x);
    end
    model_frame();
    send_frame(0, 0);
    check("max_last_addr", {19'd0, imem_addr}, 32'd8191);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
